// File: rtl/led_matrix_pkg.sv
// Shared constants and encodings for the LED-matrix frame buffer path:
// geometry, pixel width, RAM grant encoding and clear-sequencer states.
package led_matrix_pkg;

    localparam int ADDR_W       = 11;
    localparam int DATA_W       = 24;
    localparam int NUM_ROWS     = 32;
    localparam int NUM_COLS     = 64;
    localparam int STARVE_LIMIT = 16;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_SCAN  = 2'd1,
        GNT_CLEAR = 2'd2,
        GNT_HOST  = 2'd3
    } grant_e;

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_FILL = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_e;

endpackage

// File: rtl/fb_clear_seq.sv
// Clear-screen sequencer: walks every RAM word once with a latched colour,
// advancing only when the scheduler grants it the port.
module fb_clear_seq
    import led_matrix_pkg::*;
#(
    parameter int ADDR_W = led_matrix_pkg::ADDR_W,
    parameter int DATA_W = led_matrix_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_color,
    input  logic              grant_clear,
    output logic              clr_req,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data,
    output logic              clear_busy,
    output logic              clear_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] color_q, color_d;

    // Next-state logic; the counter stops on the last word instead of wrapping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        color_d = color_q;
        case (state_q)
            CLR_IDLE: begin
                if (clear_start) begin
                    state_d = CLR_FILL;
                    addr_d  = '0;
                    color_d = clear_color;
                end else begin
                    state_d = CLR_IDLE;
                end
            end
            CLR_FILL: begin
                if (grant_clear) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = CLR_DONE;
                    end else begin
                        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = CLR_FILL;
                end
            end
            CLR_DONE: begin
                state_d = CLR_IDLE;
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase
    end

    // State, address and colour registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_IDLE;
            addr_q  <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            color_q <= color_d;
        end
    end

    assign clear_busy = (state_q == CLR_FILL);
    assign clear_done = (state_q == CLR_DONE);
    assign clr_req    = clear_busy;
    assign clr_addr   = addr_q;
    assign clr_data   = color_q;

endmodule

// File: rtl/fb_access_scheduler.sv
// Single-port image RAM arbiter: scan reads beat clear and host writes, except
// when a writer has been starved long enough to earn a forced slot.
module fb_access_scheduler
    import led_matrix_pkg::*;
#(
    parameter int ADDR_W       = led_matrix_pkg::ADDR_W,
    parameter int DATA_W       = led_matrix_pkg::DATA_W,
    parameter int STARVE_LIMIT = led_matrix_pkg::STARVE_LIMIT
) (
    input  logic              clk_25mhz,
    input  logic              rst,
    input  logic              scan_rd_req,
    output logic              scan_rd_ready,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    grant_e            grant;
    logic              clr_req;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;
    logic              host_pend;
    logic              writer_pend;
    logic              writer_gnt;
    logic              force_wr;

    logic [CNT_W-1:0]  starve_cnt_q,  starve_cnt_d;
    logic              rvalid_q,      rvalid_d;
    logic [DATA_W-1:0] rdata_q,       rdata_d;

    fb_clear_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_clear_seq (
        .clk         (clk_25mhz),
        .rst         (rst),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .grant_clear (grant == GNT_CLEAR),
        .clr_req     (clr_req),
        .clr_addr    (clr_addr),
        .clr_data    (clr_data),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done)
    );

    // Host is locked out for the whole fill so a clear can never overwrite it.
    assign host_pend   = host_wr_valid & ~clr_req;
    assign writer_pend = clr_req | host_pend;
    assign writer_gnt  = (grant == GNT_CLEAR) || (grant == GNT_HOST);
    assign force_wr    = writer_pend && (starve_cnt_q == CNT_LIMIT);

    // Per-cycle grant; nothing touches the RAM while reset is asserted.
    always_comb begin
        grant = GNT_NONE;
        if (rst) begin
            grant = GNT_NONE;
        end else if (force_wr) begin
            grant = clr_req ? GNT_CLEAR : GNT_HOST;
        end else if (scan_rd_req) begin
            grant = GNT_SCAN;
        end else if (clr_req) begin
            grant = GNT_CLEAR;
        end else if (host_pend) begin
            grant = GNT_HOST;
        end else begin
            grant = GNT_NONE;
        end
    end

    // RAM port decode from the winning requester.
    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (grant)
            GNT_SCAN: begin
                mem_rd   = 1'b1;
                mem_addr = scan_addr;
            end
            GNT_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_addr;
                mem_wdata = clr_data;
            end
            GNT_HOST: begin
                mem_we    = 1'b1;
                mem_addr  = host_wr_addr;
                mem_wdata = host_wr_data;
            end
            default: begin
                mem_rd = 1'b0;
                mem_we = 1'b0;
            end
        endcase
    end

    assign scan_rd_ready = (grant == GNT_SCAN);
    assign host_wr_ready = (grant == GNT_HOST);

    // RAM data arrives the cycle after the accept, so rdata bypasses the hold
    // register on the rvalid cycle and the hold register keeps it afterwards.
    assign scan_rvalid = rvalid_q & ~rst;
    assign scan_rdata  = scan_rvalid ? mem_rdata : rdata_q;

    // Starvation counter and scan pipeline next-state.
    always_comb begin
        starve_cnt_d = '0;
        rvalid_d     = scan_rd_ready;
        rdata_d      = scan_rdata;
        if (writer_pend && !writer_gnt && (starve_cnt_q != CNT_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (writer_pend && !writer_gnt) begin
            starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = '0;
        end
    end

    // Scheduler registers.
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            starve_cnt_q <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_fb_access_scheduler.sv
// Directed bench for fb_access_scheduler with a behavioural single-port RAM.
module tb_fb_access_scheduler;

    logic        clk_25mhz = 1'b0;
    logic        rst;
    logic        scan_rd_req;
    logic        scan_rd_ready;
    logic [10:0] scan_addr;
    logic        scan_rvalid;
    logic [23:0] scan_rdata;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [10:0] host_wr_addr;
    logic [23:0] host_wr_data;
    logic        clear_start;
    logic [23:0] clear_color;
    logic        clear_busy;
    logic        clear_done;
    logic [10:0] mem_addr;
    logic        mem_rd;
    logic        mem_we;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;

    logic [23:0] ram [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_25mhz = ~clk_25mhz;

    always @(posedge clk_25mhz) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    fb_access_scheduler dut (
        .clk_25mhz     (clk_25mhz),
        .rst           (rst),
        .scan_rd_req   (scan_rd_req),
        .scan_rd_ready (scan_rd_ready),
        .scan_addr     (scan_addr),
        .scan_rvalid   (scan_rvalid),
        .scan_rdata    (scan_rdata),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .clear_start   (clear_start),
        .clear_color   (clear_color),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    task automatic tick;
        @(posedge clk_25mhz);
        #1;
    endtask

    // Stimulus only: one uncontended host write.
    task automatic host_write(input logic [10:0] a, input logic [23:0] d);
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        tick();
        host_wr_valid = 1'b0;
    endtask

    // Stimulus only: one scan read, returns what came back on the rvalid cycle.
    task automatic scan_read(input logic [10:0] a, output logic v, output logic [23:0] d);
        scan_rd_req = 1'b1;
        scan_addr   = a;
        tick();
        scan_rd_req = 1'b0;
        @(negedge clk_25mhz);
        v = scan_rvalid;
        d = scan_rdata;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; scan_rd_req = 1'b1; scan_addr = 11'h005;
        host_wr_valid = 1'b1; host_wr_addr = 11'h006; host_wr_data = 24'h123456;
        clear_start = 1'b0; clear_color = 24'h000000;
        tick(); tick();
        @(negedge clk_25mhz);
        n_cmp++; if ({scan_rvalid, clear_busy, clear_done} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {scan_rvalid, clear_busy, clear_done}); end
        n_cmp++; if (scan_rdata !== 24'h000000) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 000000", scan_rdata); end
        n_cmp++; if ({mem_rd, mem_we, scan_rd_ready, host_wr_ready} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_grant: got %b want 0000", {mem_rd, mem_we, scan_rd_ready, host_wr_ready}); end
        n_cmp++; if ({mem_addr, mem_wdata} !== 35'h0) begin
            n_bad++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
        n_cmp++; if (dut.starve_cnt_q !== 5'd0) begin
            n_bad++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt_q); end
        tick();
        rst = 1'b0; scan_rd_req = 1'b0; host_wr_valid = 1'b0;
        tick();
    endtask

    task automatic test_scan_back_to_back;
        host_write(11'h7FF, 24'hA5C3F0);
        host_write(11'h001, 24'h111111);
        host_write(11'h002, 24'h222222);
        scan_rd_req = 1'b1; scan_addr = 11'h7FF;
        @(negedge clk_25mhz);
        n_cmp++; if ({scan_rd_ready, mem_rd, mem_we, mem_addr} !== {3'b110, 11'h7FF}) begin
            n_bad++; $display("FAIL scan_accept: got rdy=%b rd=%b we=%b a=%h want 1 1 0 7ff", scan_rd_ready, mem_rd, mem_we, mem_addr); end
        tick(); scan_addr = 11'h001;
        @(negedge clk_25mhz);
        n_cmp++; if ({scan_rvalid, scan_rdata} !== {1'b1, 24'hA5C3F0}) begin
            n_bad++; $display("FAIL scan_7ff: got v=%b d=%h want 1 a5c3f0", scan_rvalid, scan_rdata); end
        tick(); scan_addr = 11'h002;
        @(negedge clk_25mhz);
        n_cmp++; if ({scan_rvalid, scan_rdata} !== {1'b1, 24'h111111}) begin
            n_bad++; $display("FAIL b2b_1: got v=%b d=%h want 1 111111", scan_rvalid, scan_rdata); end
        tick(); scan_rd_req = 1'b0;
        @(negedge clk_25mhz);
        n_cmp++; if ({scan_rvalid, scan_rdata} !== {1'b1, 24'h222222}) begin
            n_bad++; $display("FAIL b2b_2: got v=%b d=%h want 1 222222", scan_rvalid, scan_rdata); end
        tick();
        @(negedge clk_25mhz);
        n_cmp++; if ({scan_rvalid, scan_rdata} !== {1'b0, 24'h222222}) begin
            n_bad++; $display("FAIL rdata_hold: got v=%b d=%h want 0 222222", scan_rvalid, scan_rdata); end
        tick();
    endtask

    task automatic test_host;
        logic v; logic [23:0] d;
        host_wr_valid = 1'b1; host_wr_addr = 11'h040; host_wr_data = 24'h00FF00;
        @(negedge clk_25mhz);
        n_cmp++; if ({host_wr_ready, mem_we, mem_rd, mem_addr, mem_wdata} !== {3'b110, 11'h040, 24'h00FF00}) begin
            n_bad++; $display("FAIL host_write: got rdy=%b we=%b rd=%b a=%h d=%h want 1 1 0 040 00ff00",
                              host_wr_ready, mem_we, mem_rd, mem_addr, mem_wdata); end
        tick(); host_wr_valid = 1'b0;
        scan_read(11'h040, v, d);
        n_cmp++; if ({v, d} !== {1'b1, 24'h00FF00}) begin
            n_bad++; $display("FAIL host_readback: got v=%b d=%h want 1 00ff00", v, d); end
    endtask

    task automatic test_starvation;
        logic [1:0] got;
        logic [1:0] exp;
        scan_rd_req = 1'b1; scan_addr = 11'h000;
        host_wr_valid = 1'b1; host_wr_addr = 11'h100; host_wr_data = 24'hABCDEF;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk_25mhz);
            got = {host_wr_ready, scan_rd_ready};
            exp = (cyc == 17) ? 2'b10 : 2'b01;
            n_cmp++; if (got !== exp) begin
                n_bad++; $display("FAIL starve_cyc%0d: got host/scan=%b want %b", cyc, got, exp); end
            tick();
            if (cyc == 17) host_wr_valid = 1'b0;
        end
        @(negedge clk_25mhz);
        n_cmp++; if (dut.starve_cnt_q !== 5'd0) begin
            n_bad++; $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt_q); end
        tick(); scan_rd_req = 1'b0;
        tick(); tick();
        n_cmp++; if (ram[11'h100] !== 24'hABCDEF) begin
            n_bad++; $display("FAIL starve_write: got %h want abcdef", ram[11'h100]); end
    endtask

    task automatic test_clear;
        int busy_n = 0; int we_n = 0; int done_n = 0; int bad_words = 0;
        logic v; logic [23:0] d;
        clear_start = 1'b1; clear_color = 24'h112233;
        tick(); clear_start = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk_25mhz);
            if (clear_busy) busy_n++;
            if (mem_we) we_n++;
            if (clear_done) done_n++;
            // A second start mid-fill must be ignored.
            if (i == 100) begin clear_start = 1'b1; clear_color = 24'hFFFFFF; end
            else clear_start = 1'b0;
        end
        tick();
        n_cmp++; if (busy_n !== 2048) begin n_bad++; $display("FAIL clear_busy_len: got %0d want 2048", busy_n); end
        n_cmp++; if (we_n !== 2048) begin n_bad++; $display("FAIL clear_writes: got %0d want 2048", we_n); end
        n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL clear_done_pulses: got %0d want 1", done_n); end
        for (int a = 0; a < 2048; a++) if (ram[a] !== 24'h112233) bad_words++;
        n_cmp++; if (bad_words !== 0) begin n_bad++; $display("FAIL clear_fill: got %0d bad words want 0", bad_words); end
        scan_read(11'h7FF, v, d);
        n_cmp++; if ({v, d} !== {1'b1, 24'h112233}) begin
            n_bad++; $display("FAIL clear_scan_7ff: got v=%b d=%h want 1 112233", v, d); end
    endtask

    task automatic test_clear_host;
        int early = 0; logic got = 1'b0; logic done_seen = 1'b0;
        clear_start = 1'b1; clear_color = 24'h445566;
        host_wr_valid = 1'b1; host_wr_addr = 11'h123; host_wr_data = 24'h0A0B0C;
        @(negedge clk_25mhz);
        n_cmp++; if ({host_wr_ready, clear_busy} !== 2'b10) begin
            n_bad++; $display("FAIL start_and_host: got rdy/busy=%b want 10", {host_wr_ready, clear_busy}); end
        tick();
        clear_start = 1'b0; host_wr_addr = 11'h124; host_wr_data = 24'h0D0E0F;
        for (int i = 0; i < 2200; i++) begin
            @(negedge clk_25mhz);
            if (host_wr_ready && clear_busy) early++;
            if (host_wr_ready) begin got = 1'b1; done_seen = clear_done; break; end
        end
        tick(); host_wr_valid = 1'b0;
        n_cmp++; if ({got, done_seen} !== 2'b11) begin
            n_bad++; $display("FAIL host_after_clear: got granted/done=%b want 11", {got, done_seen}); end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL host_during_clear: got %0d want 0", early); end
        tick();
        n_cmp++; if ({ram[11'h123], ram[11'h124], ram[11'h125]} !== {24'h445566, 24'h0D0E0F, 24'h445566}) begin
            n_bad++; $display("FAIL clear_host_ram: got %h %h %h want 445566 0d0e0f 445566",
                              ram[11'h123], ram[11'h124], ram[11'h125]); end
    endtask

    task automatic test_reset_mid_clear;
        logic found = 1'b0; int done_n = 0; int we_n = 0;
        clear_start = 1'b1; clear_color = 24'h778899;
        tick(); clear_start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_25mhz);
            if (mem_we && mem_addr == 11'h1FF) begin found = 1'b1; break; end
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL reach_1ff: got %b want 1", found); end
        tick(); rst = 1'b1;
        @(negedge clk_25mhz);
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL write_in_reset: got %b want 0", mem_we); end
        tick(); rst = 1'b0;
        @(negedge clk_25mhz);
        n_cmp++; if ({clear_busy, clear_done} !== 2'b00) begin
            n_bad++; $display("FAIL abort_state: got busy/done=%b want 00", {clear_busy, clear_done}); end
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk_25mhz);
            if (clear_done) done_n++;
            if (mem_we) we_n++;
        end
        tick();
        n_cmp++; if ({done_n, we_n} !== {32'd0, 32'd0}) begin
            n_bad++; $display("FAIL abort_quiet: got done=%0d we=%0d want 0 0", done_n, we_n); end
        n_cmp++; if ({ram[11'h1FF], ram[11'h200], ram[11'h7FF]} !== {24'h778899, 24'h445566, 24'h445566}) begin
            n_bad++; $display("FAIL abort_ram: got %h %h %h want 778899 445566 445566",
                              ram[11'h1FF], ram[11'h200], ram[11'h7FF]); end
    endtask

    task automatic test_reset_after_scan;
        scan_rd_req = 1'b1; scan_addr = 11'h040;
        @(negedge clk_25mhz);
        n_cmp++; if (scan_rd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_scan_accept: got %b want 1", scan_rd_ready); end
        tick(); scan_rd_req = 1'b0; rst = 1'b1;
        @(negedge clk_25mhz);
        n_cmp++; if (scan_rvalid !== 1'b0) begin n_bad++; $display("FAIL rvalid_in_reset: got %b want 0", scan_rvalid); end
        tick(); rst = 1'b0;
        @(negedge clk_25mhz);
        n_cmp++; if (scan_rvalid !== 1'b0) begin n_bad++; $display("FAIL rvalid_after_reset: got %b want 0", scan_rvalid); end
        tick();
    endtask

    initial begin
        rst = 1'b1; scan_rd_req = 1'b0; scan_addr = 11'h000;
        host_wr_valid = 1'b0; host_wr_addr = 11'h000; host_wr_data = 24'h000000;
        clear_start = 1'b0; clear_color = 24'h000000;
        tick();
        test_reset();
        test_scan_back_to_back();
        test_host();
        test_starvation();
        test_clear();
        test_clear_host();
        test_reset_mid_clear();
        test_reset_after_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
